jump_charge: RTL and testbench

Converts the player's raw push-button into the 8-bit `jump_dist` charge value that the game FSM samples every game tick. The block synchronizes and debounces the button and ramps `jump_dist` while the button is held. On release it drops `jump_dist` to 0, which gives the FSM its end-of-jump edge (non-zero followed by zero). It then blocks new presses for a lockout window that covers the FSM's shift animation. It sits between the board button pin and the FSM's `jump_dist` input.

---
 rtl/jump_charge_pkg.sv | 12 +
 rtl/jump_charge_debounce.sv | 29 ++
 rtl/jump_charge.sv | 81 ++++++++
 tb/tb_jump_charge.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/jump_charge_pkg.sv
// jump_charge_pkg: shared state encodings and default tuning constants for jump_charge
package jump_charge_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHARGE = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;
  localparam int DEBOUNCE_DEF = 16;
  localparam int RATE_DIV_DEF = 2;
  localparam int MAX_DIST_DEF = 63;
  localparam int LOCKOUT_DEF  = 24;
endpackage

// File: rtl/jump_charge_debounce.sv
// btn_debounce: 2-flop synchronizer plus debounce counter for the raw jump button
module btn_debounce #(
  parameter int DEBOUNCE = 16
) (
  input  logic clk,
  input  logic restart,
  input  logic btn,
  output logic btn_db
);
  localparam int CW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic btn_s;
  assign btn_s = sync[1];
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      sync   <= '0;
      cnt    <= '0;
      btn_db <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (btn_s == btn_db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE - 1)) begin
        btn_db <= btn_s;
        cnt    <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/jump_charge.sv
// jump_charge: debounced button to ramping jump_dist charge with post-release lockout
module jump_charge
  import jump_charge_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int RATE_DIV = RATE_DIV_DEF,
  parameter int MAX_DIST = MAX_DIST_DEF,
  parameter int LOCKOUT  = LOCKOUT_DEF
) (
  input  logic       clk,
  input  logic       restart,
  input  logic       btn,
  input  logic       tick,
  output logic [7:0] jump_dist,
  output logic       charging,
  output logic       release_pulse,
  output logic       locked
);
  localparam int DW = RATE_DIV > 1 ? $clog2(RATE_DIV) : 1;
  state_t state, state_n;
  logic [DW-1:0] div_cnt, div_n;
  logic [7:0] lock_cnt, lock_n, dist_n;
  logic btn_db, rel_n;
  btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
    .clk(clk), .restart(restart), .btn(btn), .btn_db(btn_db)
  );
  always_comb begin
    state_n = state;
    dist_n  = jump_dist;
    div_n   = div_cnt;
    lock_n  = lock_cnt;
    rel_n   = tick && state == ST_CHARGE && !btn_db;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          state_n = btn_db ? ST_CHARGE : ST_IDLE;
          dist_n  = btn_db ? 8'd1 : 8'd0;
          div_n   = '0;
        end
        ST_CHARGE: begin
          if (!btn_db) begin
            state_n = ST_LOCK;
            dist_n  = 8'd0;
            lock_n  = 8'(LOCKOUT - 1);
          end else if (div_cnt == DW'(RATE_DIV - 1)) begin
            div_n  = '0;
            dist_n = jump_dist >= 8'(MAX_DIST) ? 8'(MAX_DIST) : jump_dist + 8'd1;
          end else div_n = div_cnt + DW'(1);
        end
        ST_LOCK: begin
          dist_n  = 8'd0;
          lock_n  = lock_cnt != 8'd0 ? lock_cnt - 8'd1 : lock_cnt;
          state_n = lock_cnt == 8'd0 && !btn_db ? ST_IDLE : ST_LOCK;
        end
        default: begin
          state_n = ST_IDLE;
          dist_n  = 8'd0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      state         <= ST_IDLE;
      jump_dist     <= 8'd0;
      div_cnt       <= '0;
      lock_cnt      <= 8'd0;
      charging      <= 1'b0;
      release_pulse <= 1'b0;
      locked        <= 1'b0;
    end else begin
      state         <= state_n;
      jump_dist     <= dist_n;
      div_cnt       <= div_n;
      lock_cnt      <= lock_n;
      charging      <= state_n == ST_CHARGE;
      release_pulse <= rel_n;
      locked        <= state_n == ST_LOCK;
    end
  end
endmodule

// File: tb/tb_jump_charge.sv
// tb_jump_charge: directed self-checking bench for jump_charge (DEBOUNCE=4, RATE_DIV=2, tick every clk)
module tb_jump_charge;
  logic clk = 1'b0;
  logic restart, btn, tick;
  logic [7:0] jump_dist;
  logic charging, release_pulse, locked;
  int checks = 0;
  int failures = 0;
  jump_charge #(.DEBOUNCE(4), .RATE_DIV(2), .MAX_DIST(63), .LOCKOUT(24)) dut (
    .clk(clk), .restart(restart), .btn(btn), .tick(tick),
    .jump_dist(jump_dist), .charging(charging),
    .release_pulse(release_pulse), .locked(locked)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset;
    restart = 1'b1; btn = 1'b0; tick = 1'b1;
    #2;
    checks++;
    if ({jump_dist, charging, release_pulse, locked} !== 11'd0) begin
      failures++;
      $display("FAIL reset_async outputs=%h required=0", {jump_dist, charging, release_pulse, locked});
    end
    step(3);
    #3 restart = 1'b0;
    step(5);
    checks++;
    if ({jump_dist, charging, release_pulse, locked} !== 11'd0) begin
      failures++;
      $display("FAIL reset_idle outputs=%h required=0", {jump_dist, charging, release_pulse, locked});
    end
  endtask
  task automatic test_glitch;
    btn = 1'b1;
    step(3);
    btn = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      checks++;
      if (jump_dist !== 8'd0 || charging !== 1'b0) begin
        failures++;
        $display("FAIL glitch cyc=%0d jump_dist=%0d charging=%b required 0/0", i, jump_dist, charging);
      end
    end
  endtask
  task automatic test_press_ramp;
    btn = 1'b1;
    step(6);
    checks++;
    if (jump_dist !== 8'd0) begin
      failures++;
      $display("FAIL press_early jump_dist=%0d required=0", jump_dist);
    end
    step(1);
    checks++;
    if (jump_dist !== 8'd1 || charging !== 1'b1) begin
      failures++;
      $display("FAIL press_entry jump_dist=%0d charging=%b required 1/1", jump_dist, charging);
    end
    step(1);
    checks++;
    if (jump_dist !== 8'd1) begin
      failures++;
      $display("FAIL ramp_hold jump_dist=%0d required=1", jump_dist);
    end
    step(1);
    checks++;
    if (jump_dist !== 8'd2) begin
      failures++;
      $display("FAIL ramp_inc jump_dist=%0d required=2", jump_dist);
    end
    step(16);
    checks++;
    if (jump_dist !== 8'd10) begin
      failures++;
      $display("FAIL ramp_19 jump_dist=%0d required=10", jump_dist);
    end
  endtask
  task automatic test_saturation;
    logic [7:0] prev;
    int bad;
    prev = jump_dist;
    bad = 0;
    for (int i = 1; i <= 200; i++) begin
      step(1);
      if (jump_dist < prev || jump_dist > 8'd63) bad++;
      prev = jump_dist;
      if (i == 104) begin
        checks++;
        if (jump_dist !== 8'd62) begin
          failures++;
          $display("FAIL sat_pre jump_dist=%0d required=62", jump_dist);
        end
      end
      if (i == 106) begin
        checks++;
        if (jump_dist !== 8'd63) begin
          failures++;
          $display("FAIL sat_reach jump_dist=%0d required=63", jump_dist);
        end
      end
    end
    checks++;
    if (bad != 0 || jump_dist !== 8'd63) begin
      failures++;
      $display("FAIL sat_hold jump_dist=%0d bad_steps=%0d required 63/0", jump_dist, bad);
    end
  endtask
  task automatic test_release;
    btn = 1'b0;
    step(6);
    checks++;
    if (jump_dist !== 8'd63 || charging !== 1'b1) begin
      failures++;
      $display("FAIL release_early jump_dist=%0d charging=%b required 63/1", jump_dist, charging);
    end
    step(1);
    checks++;
    if (jump_dist !== 8'd0 || release_pulse !== 1'b1 || locked !== 1'b1 || charging !== 1'b0) begin
      failures++;
      $display("FAIL release_edge jump_dist=%0d pulse=%b locked=%b charging=%b required 0/1/1/0",
               jump_dist, release_pulse, locked, charging);
    end
    for (int i = 0; i < 23; i++) begin
      step(1);
      checks++;
      if (locked !== 1'b1 || release_pulse !== 1'b0 || jump_dist !== 8'd0) begin
        failures++;
        $display("FAIL lockout_hold cyc=%0d locked=%b pulse=%b jump_dist=%0d required 1/0/0",
                 i, locked, release_pulse, jump_dist);
      end
    end
    step(1);
    checks++;
    if (locked !== 1'b0 || jump_dist !== 8'd0) begin
      failures++;
      $display("FAIL lockout_end locked=%b jump_dist=%0d required 0/0", locked, jump_dist);
    end
  endtask
  task automatic test_lockout_repress;
    btn = 1'b1;
    step(7);
    checks++;
    if (jump_dist !== 8'd1) begin
      failures++;
      $display("FAIL repress_charge jump_dist=%0d required=1", jump_dist);
    end
    step(5);
    btn = 1'b0;
    step(7);
    checks++;
    if (locked !== 1'b1 || release_pulse !== 1'b1) begin
      failures++;
      $display("FAIL repress_lock locked=%b pulse=%b required 1/1", locked, release_pulse);
    end
    step(3);
    btn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      checks++;
      if (locked !== 1'b1 || jump_dist !== 8'd0 || charging !== 1'b0) begin
        failures++;
        $display("FAIL repress_held cyc=%0d locked=%b jump_dist=%0d charging=%b required 1/0/0",
                 i, locked, jump_dist, charging);
      end
    end
    btn = 1'b0;
    step(6);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL repress_release_early locked=%b required=1", locked);
    end
    step(1);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL repress_idle locked=%b required=0", locked);
    end
    btn = 1'b1;
    step(6);
    checks++;
    if (jump_dist !== 8'd0) begin
      failures++;
      $display("FAIL fresh_early jump_dist=%0d required=0", jump_dist);
    end
    step(1);
    checks++;
    if (jump_dist !== 8'd1 || charging !== 1'b1) begin
      failures++;
      $display("FAIL fresh_press jump_dist=%0d charging=%b required 1/1", jump_dist, charging);
    end
  endtask
  task automatic test_async_reset;
    step(4);
    checks++;
    if (jump_dist !== 8'd3) begin
      failures++;
      $display("FAIL pre_reset jump_dist=%0d required=3", jump_dist);
    end
    btn = 1'b0;
    #3 restart = 1'b1;
    #1;
    checks++;
    if ({jump_dist, charging, release_pulse, locked} !== 11'd0) begin
      failures++;
      $display("FAIL reset_mid outputs=%h required=0", {jump_dist, charging, release_pulse, locked});
    end
    step(2);
    #3 restart = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      checks++;
      if (locked !== 1'b0 || release_pulse !== 1'b0 || jump_dist !== 8'd0 || charging !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_release cyc=%0d locked=%b pulse=%b jump_dist=%0d charging=%b required 0",
                 i, locked, release_pulse, jump_dist, charging);
      end
    end
  endtask
  initial begin
    test_reset;
    test_glitch;
    test_press_ramp;
    test_saturation;
    test_release;
    test_lockout_repress;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
